agu_issue_arb: RTL and testbench
================================

# agu_issue_arb

Issue arbiter and flow controller for the single address-generation unit. Shares the AGU between the load and store issue queues with round-robin priority. The AGU has no downstream ready, so this block gates issue against a credit count of free LSQ address-entry slots. After a pipeline flush it holds issue off for a fixed number of cycles. It sits between the load/store reservation stations and `fu_agu`.

## Interface
Parameters:
- `LSQ_DEPTH`, 8: number of LSQ address slots, which is the maximum number of credits.
- `FLUSH_HOLD_CYCLES`, 2: number of cycles in which no grants are made after a flush. Must be ≥1.

Ports:
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `flush` in 1: backend flush (mispredict).
- `ld_valid` in 1: load RS has an AGU-ready uop.
- `ld_ready` out 1: load uop accepted this cycle.
- `ld_uop` in `agu_reg_t`: load uop payload.
- `st_valid` in 1: store RS has an AGU-ready uop.
- `st_ready` out 1: store uop accepted this cycle.
- `st_uop` in `agu_reg_t`: store uop payload.
- `agu_valid` out 1: issue to AGU.
- `agu_ready` in 1: AGU accept; tied high today.
- `agu_uop` out `agu_reg_t`: selected payload.
- `lsq_dealloc` in 1: one LSQ address slot freed this cycle.
- `credit_cnt` out `$clog2(LSQ_DEPTH+1)`: current credits, for debug.

## Operation
- FSM has two states:
  - RUN: grants are permitted.
  - HOLD: no grants.
- Transitions:
  - RUN→HOLD on `flush`.
  - HOLD exits to RUN when `hold_cnt` reaches `FLUSH_HOLD_CYCLES-1`.
  - `flush` while in HOLD reloads `hold_cnt` to 0.
- Grant eligibility: state==RUN, `credit_cnt`≠0, `agu_ready`, and `flush`=0.
- Selection:
  - Only one requester valid: that one wins.
  - Both valid: the side indicated by `prio` wins (0=load, 1=store).
  - `prio` flips to the loser only after a contended grant.
  - Uncontended grants leave `prio` unchanged.
- `agu_valid` = grant made. `agu_uop` is muxed from the winner, or `'x` when there is no grant. `ld_ready`/`st_ready` assert only for the winner.
- Credits:
  - Each grant decrements. Each `lsq_dealloc` increments.
  - Grant and dealloc in the same cycle: net unchanged.
  - A dealloc credit is usable only from the next cycle; eligibility uses the registered count.
  - Dealloc when already at `LSQ_DEPTH`: saturate, and fire an assertion (simulation only).
  - In HOLD, `lsq_dealloc` is ignored. On HOLD→RUN, `credit_cnt` reloads to `LSQ_DEPTH`, because the LSQ is flushed as well.
- `flush` in RUN: no grant that cycle, and the FSM enters HOLD with `hold_cnt`=0.

## Timing
- Grant is combinational: request and grant happen in the same cycle. `fu_agu` registers the uop, and the LSQ sees the address one cycle after the grant.
- Reset values:
  - state=RUN, `prio`=0, `credit_cnt`=`LSQ_DEPTH`, `hold_cnt`=0.
  - `agu_valid`, `ld_ready`, `st_ready` are forced to 0 while `rst`=1.
- Throughput: one grant per cycle while credits are available.
- Zero credits: no grants, and requesters stall with their valid held high.
- `credit_cnt` is never negative. A grant requires a non-zero count.
- `rst` during HOLD: return to RUN immediately with full credits.

## Configuration
- Macro `AGU_ARB_PERF_EN`.
- When defined, three 32-bit output ports are added:
  - `perf_ld_grants`: counts load grants.
  - `perf_st_grants`: counts store grants.
  - `perf_credit_stalls`: counts cycles with a request valid, state RUN, and `credit_cnt`=0.
- All three counters reset to 0 and wrap on overflow.
- When not defined, the ports and counters are absent. Arbitration behaviour is identical either way.

## Structure
- `lsu_types` package additions:
  - `agu_arb_state_e` enum (RUN, HOLD).
  - Existing `agu_reg_t` is reused.
- `cpu_params` package addition: `LSQ_DEPTH` default.
- One sub-module: `rr_arb2`, a 2-way round-robin arbiter holding the `prio` flop. Its inputs are req[1:0] and an enable; its output is a one-hot grant.
- The credit counter, FSM and perf counters live in the top module.

## Test plan
- Loads only, 10 consecutive cycles with no dealloc, `LSQ_DEPTH`=8 → 8 grants, then `ld_ready`=0; `credit_cnt`=0; `perf_credit_stalls` increments by 2.
- Both valid every cycle with dealloc every cycle → grants alternate L,S,L,S starting with load; `credit_cnt` stays at 8.
- `credit_cnt`=0, both valid, `lsq_dealloc`=1 → no grant that cycle; grant in the next cycle; `credit_cnt` returns to 0.
- `flush` at credit 3 with both valid → no grant for 1+2 cycles; `credit_cnt`=8 on re-entry to RUN; the first grant goes to the current `prio` side.
- Second `flush` during HOLD cycle 1 → HOLD is extended so that 2 further cycles have no grant.
- `rst` asserted during HOLD with credits 0 → next cycle state RUN, `credit_cnt`=8, `prio`=0, all outputs valid/ready low during reset.

Source files
------------

// File: rtl/agu_issue_arb_pkg.sv
// agu_issue_arb_pkg: shared types and defaults for the AGU issue arbiter
//   LSQ_DEPTH_DEFAULT  default number of LSQ address slots (credit ceiling)
//   agu_arb_state_e    arbiter FSM state: RUN grants, HOLD blocks after a flush
//   agu_reg_t          uop payload carried from the reservation stations to fu_agu
package agu_issue_arb_pkg;

    localparam int LSQ_DEPTH_DEFAULT = 8;

    typedef enum logic {
        RUN  = 1'b0,
        HOLD = 1'b1
    } agu_arb_state_e;

    typedef struct packed {
        logic [5:0]  rob_idx;
        logic [6:0]  base_preg;
        logic [31:0] imm;
        logic [1:0]  size;
        logic        is_signed;
    } agu_reg_t;

endpackage

// File: rtl/agu_issue_arb_rr_arb2.sv
// rr_arb2: two-way round-robin arbiter owning the priority flop
//   clk/rst  clock, synchronous active-high reset (priority returns to requester 0)
//   req      request vector, bit 0 = load, bit 1 = store
//   en       grants allowed this cycle
//   gnt      one-hot grant (all zero when disabled or idle)
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] gnt
);

    logic prio;

    always_comb gnt = !en ? 2'b00 : (&req) ? (prio ? 2'b10 : 2'b01) : req;

    // Only a contended grant hands priority to the side that lost it.
    always_ff @(posedge clk) prio <= rst ? 1'b0 : (en && &req) ? ~prio : prio;

endmodule

// File: rtl/agu_issue_arb.sv
// agu_issue_arb: round-robin load/store issue into the AGU, gated by LSQ credits and a post-flush hold
//   clk/rst                      clock, synchronous active-high reset
//   flush                        backend flush; blocks grants and starts the hold window
//   ld_valid/ld_ready/ld_uop     load RS handshake and payload
//   st_valid/st_ready/st_uop     store RS handshake and payload
//   agu_valid/agu_ready/agu_uop  issue to fu_agu
//   lsq_dealloc                  one LSQ address slot returned this cycle
//   credit_cnt                   free LSQ address slots (debug)
//   AGU_ARB_PERF_EN              when defined, adds perf_ld_grants, perf_st_grants, perf_credit_stalls
module agu_issue_arb
    import agu_issue_arb_pkg::*;
#(
    parameter int LSQ_DEPTH         = LSQ_DEPTH_DEFAULT,
    parameter int FLUSH_HOLD_CYCLES = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           flush,
    input  logic                           ld_valid,
    output logic                           ld_ready,
    input  agu_reg_t                       ld_uop,
    input  logic                           st_valid,
    output logic                           st_ready,
    input  agu_reg_t                       st_uop,
    output logic                           agu_valid,
    input  logic                           agu_ready,
    output agu_reg_t                       agu_uop,
    input  logic                           lsq_dealloc,
    output logic [$clog2(LSQ_DEPTH+1)-1:0] credit_cnt
`ifdef AGU_ARB_PERF_EN
    ,
    output logic [31:0]                    perf_ld_grants,
    output logic [31:0]                    perf_st_grants,
    output logic [31:0]                    perf_credit_stalls
`endif
);

    localparam int CW = $clog2(LSQ_DEPTH + 1);
    localparam int HW = (FLUSH_HOLD_CYCLES > 1) ? $clog2(FLUSH_HOLD_CYCLES) : 1;
    localparam logic [CW-1:0] FULL = CW'(LSQ_DEPTH);
    localparam logic [HW-1:0] HOLD_LAST = HW'(FLUSH_HOLD_CYCLES - 1);

    agu_arb_state_e state, state_nxt;
    logic [HW-1:0]  hold_cnt, hold_cnt_nxt;
    logic [CW-1:0]  credit_nxt;
    logic           run, hold_done, en;
    logic [1:0]     gnt;

    assign run       = state == RUN;
    assign hold_done = !run && hold_cnt == HOLD_LAST;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= RUN;
            hold_cnt   <= '0;
            credit_cnt <= FULL;
        end else begin
            state      <= state_nxt;
            hold_cnt   <= hold_cnt_nxt;
            credit_cnt <= credit_nxt;
        end
    end

    // A flush always wins: it enters HOLD from RUN and restarts the window from HOLD.
    // Leaving HOLD refills credits because the LSQ was flushed alongside us.
    // Dealloc while idle at full credit saturates instead of wrapping.
    always_comb begin
        state_nxt    = flush ? HOLD : hold_done ? RUN : state;
        hold_cnt_nxt = (flush || run || hold_done) ? '0 : hold_cnt + 1'b1;
        credit_nxt   = (hold_done && !flush) ? FULL :
                       !run ? credit_cnt :
                       (agu_valid && !lsq_dealloc) ? credit_cnt - 1'b1 :
                       (!agu_valid && lsq_dealloc && credit_cnt != FULL) ? credit_cnt + 1'b1 :
                       credit_cnt;
    end

    // Eligibility uses the registered credit count, so a same-cycle dealloc cannot unblock a grant.
    always_comb begin
        en        = run && credit_cnt != '0 && agu_ready && !flush && !rst;
        agu_valid = |gnt;
        ld_ready  = gnt[0];
        st_ready  = gnt[1];
        agu_uop   = gnt[1] ? st_uop : gnt[0] ? ld_uop : 'x;
    end

    rr_arb2 u_rr_arb2 (
        .clk (clk),
        .rst (rst),
        .req ({st_valid, ld_valid}),
        .en  (en),
        .gnt (gnt)
    );

`ifdef AGU_ARB_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_ld_grants     <= '0;
            perf_st_grants     <= '0;
            perf_credit_stalls <= '0;
        end else begin
            perf_ld_grants     <= perf_ld_grants + 32'(ld_ready);
            perf_st_grants     <= perf_st_grants + 32'(st_ready);
            perf_credit_stalls <= perf_credit_stalls + 32'((ld_valid || st_valid) && run && credit_cnt == '0);
        end
    end
`endif

`ifndef SYNTHESIS
    a_credit_overflow: assert property (@(posedge clk) disable iff (rst)
        !(run && lsq_dealloc && !agu_valid && credit_cnt == FULL))
        else $error("agu_issue_arb: lsq_dealloc with all %0d credits already free", LSQ_DEPTH);
`endif

endmodule

// File: tb/tb_agu_issue_arb.sv
// tb_agu_issue_arb: scenario tests plus randomized run against a countdown-based reference model
module tb_agu_issue_arb;
    import agu_issue_arb_pkg::*;

    localparam int DEPTH = 8;
    localparam int FHC   = 2;

    logic     clk = 0, rst = 1, flush = 0, ld_valid = 0, st_valid = 0, agu_ready = 1, lsq_dealloc = 0;
    agu_reg_t ld_uop = '0, st_uop = '0, agu_uop;
    logic     ld_ready, st_ready, agu_valid;
    logic [3:0] credit_cnt;
`ifdef AGU_ARB_PERF_EN
    logic [31:0] perf_ld_grants, perf_st_grants, perf_credit_stalls;
`endif

    int tests_run = 0, fails = 0;
    int m_credit, m_prio, m_hold, e_credit;
    logic e_ld, e_st, o_ld, o_st, o_v;
    agu_reg_t o_uop, e_uop;
    logic [3:0] o_credit;

    always #5 clk = ~clk;

    agu_issue_arb #(.LSQ_DEPTH(DEPTH), .FLUSH_HOLD_CYCLES(FHC)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_uop(ld_uop),
        .st_valid(st_valid), .st_ready(st_ready), .st_uop(st_uop),
        .agu_valid(agu_valid), .agu_ready(agu_ready), .agu_uop(agu_uop),
        .lsq_dealloc(lsq_dealloc), .credit_cnt(credit_cnt)
`ifdef AGU_ARB_PERF_EN
        , .perf_ld_grants(perf_ld_grants), .perf_st_grants(perf_st_grants),
        .perf_credit_stalls(perf_credit_stalls)
`endif
    );

    function automatic agu_reg_t rand_uop();
        logic [63:0] r;
        r = {$urandom, $urandom};
        return agu_reg_t'(r[$bits(agu_reg_t)-1:0]);
    endfunction

    // Model: m_hold counts remaining no-grant cycles after a flush; 0 means grants allowed.
    task automatic cycle(input logic l, input logic s, input logic d, input logic f);
        logic elig;
        ld_valid = l; st_valid = s; lsq_dealloc = d; flush = f;
        ld_uop = rand_uop(); st_uop = rand_uop();
        #2;
        elig = m_hold == 0 && m_credit > 0 && !f;
        e_ld = elig && l && (!s || m_prio == 0);
        e_st = elig && s && (!l || m_prio == 1);
        e_uop = e_st ? st_uop : ld_uop;
        e_credit = m_credit;
        o_ld = ld_ready; o_st = st_ready; o_v = agu_valid; o_uop = agu_uop; o_credit = credit_cnt;
        @(posedge clk); #1;
        if (l && s && (e_ld || e_st)) m_prio = e_ld ? 1 : 0;
        if (m_hold == 0) begin
            m_credit = m_credit - ((e_ld || e_st) ? 1 : 0) + (d ? 1 : 0);
            if (m_credit > DEPTH) m_credit = DEPTH;
        end
        if (f) m_hold = FHC;
        else if (m_hold > 0) begin
            m_hold--;
            if (m_hold == 0) m_credit = DEPTH;
        end
    endtask

    task automatic do_reset();
        rst = 1; ld_valid = 0; st_valid = 0; flush = 0; lsq_dealloc = 0;
        @(posedge clk); #1;
        rst = 0;
        m_credit = DEPTH; m_prio = 0; m_hold = 0;
    endtask

    task automatic test_reset();
        rst = 1; ld_valid = 1; st_valid = 1;
        #2;
        tests_run++;
        if ({agu_valid, ld_ready, st_ready} !== 3'b000) begin
            fails++; $display("FAIL reset_outputs: got %b need 000", {agu_valid, ld_ready, st_ready});
        end
        @(posedge clk); #1;
        tests_run++;
        if (credit_cnt !== 4'(DEPTH)) begin
            fails++; $display("FAIL reset_credit: got %0d need %0d", credit_cnt, DEPTH);
        end
        rst = 0; m_credit = DEPTH; m_prio = 0; m_hold = 0;
        cycle(1, 1, 0, 0);
        tests_run++;
        if ({o_v, o_ld, o_st} !== 3'b110) begin
            fails++; $display("FAIL reset_first_prio: got %b need 110", {o_v, o_ld, o_st});
        end
    endtask

    task automatic test_loads_only();
        int grants = 0;
`ifdef AGU_ARB_PERF_EN
        logic [31:0] stalls0;
`endif
        do_reset();
`ifdef AGU_ARB_PERF_EN
        stalls0 = perf_credit_stalls;
`endif
        for (int i = 0; i < 10; i++) begin
            cycle(1, 0, 0, 0);
            grants += o_ld ? 1 : 0;
            tests_run++;
            if (o_ld !== (i < DEPTH) || o_st !== 1'b0 || (o_ld && o_uop !== e_uop)) begin
                fails++; $display("FAIL loads_only cyc%0d: ld_ready=%b st_ready=%b need %b 0", i, o_ld, o_st, i < DEPTH);
            end
        end
        tests_run++;
        if (grants != DEPTH || credit_cnt !== 4'd0) begin
            fails++; $display("FAIL loads_only_total: grants=%0d credit=%0d need %0d 0", grants, credit_cnt, DEPTH);
        end
`ifdef AGU_ARB_PERF_EN
        tests_run++;
        if (perf_credit_stalls - stalls0 !== 32'd2) begin
            fails++; $display("FAIL perf_stalls: got %0d need 2", perf_credit_stalls - stalls0);
        end
`endif
    endtask

    task automatic test_alternate();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            cycle(1, 1, 1, 0);
            tests_run++;
            if (o_ld !== (i % 2 == 0) || o_st !== (i % 2 == 1) || o_uop !== e_uop || credit_cnt !== 4'(DEPTH)) begin
                fails++; $display("FAIL alternate cyc%0d: ld=%b st=%b credit=%0d need %b %b %0d",
                                  i, o_ld, o_st, credit_cnt, i % 2 == 0, i % 2 == 1, DEPTH);
            end
        end
    endtask

    task automatic test_zero_credit_dealloc();
        do_reset();
        repeat (DEPTH) cycle(1, 0, 0, 0);
        cycle(1, 1, 1, 0);
        tests_run++;
        if (o_v !== 1'b0 || o_credit !== 4'd0) begin
            fails++; $display("FAIL zero_credit_nogrant: valid=%b credit=%0d need 0 0", o_v, o_credit);
        end
        cycle(1, 1, 0, 0);
        tests_run++;
        if ({o_v, o_ld, o_st} !== 3'b110 || o_credit !== 4'd1 || credit_cnt !== 4'd0) begin
            fails++; $display("FAIL zero_credit_regrant: got %b credit %0d->%0d need 110 1->0",
                              {o_v, o_ld, o_st}, o_credit, credit_cnt);
        end
    endtask

    task automatic test_flush();
        do_reset();
        cycle(1, 1, 0, 0);
        repeat (4) cycle(1, 0, 0, 0);
        cycle(1, 1, 0, 1);
        tests_run++;
        if (o_v !== 1'b0 || o_credit !== 4'd3) begin
            fails++; $display("FAIL flush_cycle: valid=%b credit=%0d need 0 3", o_v, o_credit);
        end
        for (int i = 0; i < FHC; i++) begin
            cycle(1, 1, 1, 0);
            tests_run++;
            if (o_v !== 1'b0 || o_credit !== 4'd3) begin
                fails++; $display("FAIL flush_hold%0d: valid=%b credit=%0d need 0 3", i, o_v, o_credit);
            end
        end
        cycle(1, 1, 0, 0);
        tests_run++;
        if ({o_v, o_ld, o_st} !== 3'b101 || o_credit !== 4'(DEPTH) || o_uop !== e_uop) begin
            fails++; $display("FAIL flush_reentry: got %b credit=%0d need 101 %0d", {o_v, o_ld, o_st}, o_credit, DEPTH);
        end
    endtask

    task automatic test_flush_extend();
        do_reset();
        cycle(1, 1, 0, 1);
        cycle(1, 1, 0, 1);
        tests_run++;
        if (o_v !== 1'b0) begin
            fails++; $display("FAIL extend_hold_flush: valid=%b need 0", o_v);
        end
        for (int i = 0; i < FHC; i++) begin
            cycle(1, 1, 0, 0);
            tests_run++;
            if (o_v !== 1'b0) begin
                fails++; $display("FAIL extend_hold%0d: valid=%b need 0", i, o_v);
            end
        end
        cycle(1, 1, 0, 0);
        tests_run++;
        if ({o_v, o_ld, o_st} !== 3'b110 || o_credit !== 4'(DEPTH)) begin
            fails++; $display("FAIL extend_reentry: got %b credit=%0d need 110 %0d", {o_v, o_ld, o_st}, o_credit, DEPTH);
        end
    endtask

    task automatic test_rst_in_hold();
        do_reset();
        cycle(1, 1, 0, 0);
        repeat (DEPTH - 1) cycle(1, 0, 0, 0);
        cycle(1, 1, 0, 1);
        rst = 1; ld_valid = 1; st_valid = 1; flush = 0;
        #2;
        tests_run++;
        if ({agu_valid, ld_ready, st_ready} !== 3'b000) begin
            fails++; $display("FAIL rst_hold_outputs: got %b need 000", {agu_valid, ld_ready, st_ready});
        end
        @(posedge clk); #1;
        rst = 0; m_credit = DEPTH; m_prio = 0; m_hold = 0;
        tests_run++;
        if (credit_cnt !== 4'(DEPTH)) begin
            fails++; $display("FAIL rst_hold_credit: got %0d need %0d", credit_cnt, DEPTH);
        end
        cycle(1, 1, 0, 0);
        tests_run++;
        if ({o_v, o_ld, o_st} !== 3'b110) begin
            fails++; $display("FAIL rst_hold_run: got %b need 110", {o_v, o_ld, o_st});
        end
    endtask

    task automatic test_random();
        logic l, s, d, f;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            l = 1'($urandom); s = 1'($urandom);
            f = $urandom_range(0, 24) == 0;
            d = m_credit < DEPTH && ($urandom_range(0, 2) != 0);
            cycle(l, s, d, f);
            tests_run++;
            if ({o_v, o_ld, o_st} !== {e_ld | e_st, e_ld, e_st} || o_credit !== 4'(e_credit)
                || ((e_ld | e_st) && o_uop !== e_uop)) begin
                fails++; $display("FAIL random cyc%0d: grant=%b credit=%0d need %b %0d",
                                  i, {o_v, o_ld, o_st}, o_credit, {e_ld | e_st, e_ld, e_st}, e_credit);
            end
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_loads_only();
        test_alternate();
        test_zero_credit_dealloc();
        test_flush();
        test_flush_extend();
        test_rst_in_hold();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
